// File: rtl/cpu_fetch.sv
// Instruction fetch stage: owns the PC, issues single-cycle-latency word reads,
// buffers returned words with their PCs in a small prefetch FIFO, and presents
// the FIFO head to decode over a valid/ready handshake. A branch redirect
// flushes every fetched word and restarts fetch at the target.
module cpu_fetch #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned INST_W   = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_en,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              br_valid,
  input  logic [PC_W-1:0]   br_target,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  // Fetch state
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;
  logic [PC_W-1:0]   tag_q, tag_d;

  // Prefetch FIFO state
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [INST_W-1:0] fifo_inst_q [DEPTH];
  logic [INST_W-1:0] fifo_inst_d [DEPTH];
  logic [PC_W-1:0]   fifo_pc_q   [DEPTH];
  logic [PC_W-1:0]   fifo_pc_d   [DEPTH];

  // Per-cycle control
  logic credit_ok;
  logic issue;
  logic push;
  logic pop;

  // Control decode: credit check counts the outstanding read as an occupied slot
  // so a returning word always has room. Issue is held off in reset so the
  // request line reads idle while rst_n is low.
  always_comb begin
    credit_ok = (SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(DEPTH);
    issue     = rst_n && !br_valid && credit_ok;
    push      = inflight_q && !kill_q && !br_valid;
    pop       = (count_q != '0) && inst_ready;
  end

  // Fetch-side next state: PC advance, outstanding-read tracking, redirect
  always_comb begin
    pc_d       = pc_q;
    inflight_d = issue;
    kill_d     = 1'b0;
    tag_d      = tag_q;
    if (br_valid) begin
      pc_d   = br_target;
      // Any read still outstanding across a redirect edge belongs to the old
      // path; mark it so its data can never enter the FIFO.
      kill_d = inflight_q;
    end else if (issue) begin
      pc_d  = pc_q + PC_W'(1);
      tag_d = pc_q;
    end
  end

  // FIFO next state: flush on redirect, otherwise independent push and pop
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    if (br_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_inst_d[wr_ptr_q] = imem_rdata;
        fifo_pc_d[wr_ptr_q]   = tag_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Fetch-side registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= PC_W'(RESET_PC);
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      tag_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      tag_q      <= tag_d;
    end
  end

  // FIFO registers; storage is cleared so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_inst_q[i] <= fifo_inst_d[i];
        fifo_pc_q[i]   <= fifo_pc_d[i];
      end
    end
  end

  // Output drive: memory request from PC, decode view is the FIFO head
  always_comb begin
    imem_en    = issue;
    imem_addr  = pc_q;
    inst_valid = (count_q != '0);
    inst_data  = fifo_inst_q[rd_ptr_q];
    inst_pc    = fifo_pc_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: synchronous instruction memory, a queue-level model of
// the fetched stream checked every cycle, and directed literal checks.
module tb_cpu_fetch;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        br_valid;
  logic [7:0]  br_target;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [7:0]  inst_pc;
  logic        inst_ready;

  int total = 0;
  int bad   = 0;

  logic [15:0] imem [256];

  cpu_fetch #(.PC_W(8), .INST_W(16), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'(16'h1000 + i);
    imem_rdata = 16'h0;
  end

  // Synchronous memory, one-cycle read latency
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem[imem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected stream as a queue of PCs not yet accepted by decode
  logic [7:0] m_q [$];
  logic       m_infl;
  logic [7:0] m_infl_pc;
  logic [7:0] m_fpc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_infl    = 1'b0;
      m_infl_pc = 8'h0;
      m_fpc     = 8'h0;
    end else if (br_valid) begin
      m_q.delete();
      m_infl = 1'b0;
      m_fpc  = br_target;
    end else begin
      int  sz;
      logic do_issue;
      sz       = m_q.size();
      do_issue = (sz + int'(m_infl)) < int'(DEPTH);
      if (sz > 0 && inst_ready) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_pc);
      m_infl = do_issue;
      if (do_issue) begin
        m_infl_pc = m_fpc;
        m_fpc     = m_fpc + 8'd1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic exp_en;
      exp_en = !br_valid && ((m_q.size() + int'(m_infl)) < int'(DEPTH));
      chk("imem_en", 32'(imem_en), 32'(exp_en));
      if (exp_en) chk("imem_addr", 32'(imem_addr), 32'(m_fpc));
      chk("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("inst_pc", 32'(inst_pc), 32'(m_q[0]));
        chk("inst_data", 32'(inst_data), 32'(imem[m_q[0]]));
      end
    end
  end

  task automatic tick(input logic br, input logic [7:0] tgt, input logic rdy);
    @(posedge clk);
    #1;
    br_valid   = br;
    br_target  = tgt;
    inst_ready = rdy;
  endtask

  // Bounded wait for a valid head; ends sampled at a negedge
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!inst_valid && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk(name, 32'(inst_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    br_valid   = 1'b0;
    br_target  = 8'h0;
    inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", 32'(inst_data), 32'd0);
    chk("rst_inst_pc", 32'(inst_pc), 32'd0);

    // Streaming start-up latency
    @(posedge clk); #1; rst_n = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    chk("c1_en", 32'(imem_en), 32'd1);
    chk("c1_addr", 32'(imem_addr), 32'd0);
    chk("c1_valid", 32'(inst_valid), 32'd0);
    tick(0, 8'h0, 1); @(negedge clk);
    chk("c2_addr", 32'(imem_addr), 32'd1);
    chk("c2_valid", 32'(inst_valid), 32'd0);
    tick(0, 8'h0, 1); @(negedge clk);
    chk("c3_valid", 32'(inst_valid), 32'd1);
    chk("c3_pc", 32'(inst_pc), 32'd0);
    chk("c3_data", 32'(inst_data), 32'h1000);
    tick(0, 8'h0, 1); @(negedge clk);
    chk("c4_pc", 32'(inst_pc), 32'd1);
    chk("c4_data", 32'(inst_data), 32'h1001);

    // Backpressure fills exactly DEPTH words, then drains in order without gaps
    repeat (10) tick(0, 8'h0, 0);
    @(negedge clk);
    chk("full_en", 32'(imem_en), 32'd0);
    chk("full_addr", 32'(imem_addr), 32'd6);
    chk("full_head", 32'(inst_pc), 32'd2);
    tick(0, 8'h0, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("drain_pc", 32'(inst_pc), 32'(2 + i));
      tick(0, 8'h0, 1);
    end

    // Redirect flushes buffered and inflight words
    tick(1, 8'h40, 1);
    @(negedge clk);
    chk("br_en_low", 32'(imem_en), 32'd0);
    tick(0, 8'h0, 1);
    @(negedge clk);
    chk("br_flushed", 32'(inst_valid), 32'd0);
    chk("br_resume_addr", 32'(imem_addr), 32'h40);
    wait_valid("br_wait");
    chk("br_pc", 32'(inst_pc), 32'h40);
    chk("br_data", 32'(inst_data), 32'h1040);

    // PC wraps 0xFF -> 0x00
    tick(1, 8'hFE, 1);
    tick(0, 8'h0, 1);
    wait_valid("wrap_wait");
    chk("wrap_pc0", 32'(inst_pc), 32'hFE);
    tick(0, 8'h0, 1); @(negedge clk);
    chk("wrap_pc1", 32'(inst_pc), 32'hFF);
    tick(0, 8'h0, 1); @(negedge clk);
    chk("wrap_pc2", 32'(inst_pc), 32'h00);
    chk("wrap_data2", 32'(inst_data), 32'h1000);
    tick(0, 8'h0, 1); @(negedge clk);
    chk("wrap_pc3", 32'(inst_pc), 32'h01);

    // Back-to-back redirects: last target wins
    tick(1, 8'h10, 1);
    tick(1, 8'h20, 1);
    tick(0, 8'h0, 1);
    wait_valid("b2b_wait");
    chk("b2b_pc", 32'(inst_pc), 32'h20);

    // Random backpressure and redirects, checked by the model
    for (int i = 0; i < 300; i++) begin
      tick(logic'($urandom_range(0, 11) == 0), 8'($urandom), logic'($urandom_range(0, 1)));
    end
    repeat (4) tick(0, 8'h0, 1);

    // Asynchronous reset with FIFO partly full and a read outstanding
    repeat (3) tick(0, 8'h0, 0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(inst_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_imem_en", 32'(imem_en), 32'd0);
    chk("arst_imem_addr", 32'(imem_addr), 32'd0);
    chk("arst_inst_valid", 32'(inst_valid), 32'd0);
    chk("arst_inst_data", 32'(inst_data), 32'd0);
    chk("arst_inst_pc", 32'(inst_pc), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    chk("rerst_en", 32'(imem_en), 32'd1);
    chk("rerst_addr", 32'(imem_addr), 32'd0);
    tick(0, 8'h0, 1);
    wait_valid("rerst_wait");
    chk("rerst_pc", 32'(inst_pc), 32'd0);
    chk("rerst_data", 32'(inst_data), 32'h1000);
    repeat (4) tick(0, 8'h0, 1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
